serial_subtractor: RTL

//  Bit-serial subtractor computing diff = a - b - bin over WIDTH clock cycles,
//  one bit per cycle, LSB first, through a single full-subtractor with a

---
 rtl/serial_subtractor_if.sv | 37 +++
 rtl/serial_subtractor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
//   Request/result bundle for the bit-serial subtractor.
//   master : controller side, drives start/a/b/bin and observes status/results
//   slave  : subtractor side, samples the request and drives busy/done/results
//   start  request pulse (or level for back-to-back operation)
//   a, b   minuend / subtrahend, WIDTH bits
//   bin    borrow-in
//   busy   high while the subtractor is stepping through bits
//   done   one-cycle pulse, results valid
//   diff   a - b - bin modulo 2^WIDTH
//   bout   unsigned borrow-out
//   ovf    two's-complement overflow
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
//   through a single full-subtractor with a registered borrow. An operation
//   takes WIDTH RUN cycles followed by a one-cycle DONE; start sampled in
//   DONE chains the next operation without passing through IDLE.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    serial_subtractor_if.slave (start/a/b/bin in, busy/done/diff/bout/ovf out)
// ----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;         // minuend, shifted right each RUN cycle
  logic [WIDTH-1:0] b_q, b_d;         // subtrahend, shifted right each RUN cycle
  logic [WIDTH-1:0] res_q, res_d;     // result bits enter at the MSB end
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;       // running borrow
  logic             a_msb_q, a_msb_d; // operand sign bits, kept for ovf since
  logic             b_msb_q, b_msb_d; // the operands are shifted away
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor on the current LSBs.
  assign d_bit     = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_shift = {d_bit, res_q[WIDTH-1:1]};

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        br_d  = br_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: publish results on the same edge that enters DONE.
          // d_bit is the result MSB here.
          state_d = S_DONE;
          diff_d  = res_shift;
          bout_d  = br_nxt;
          ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule
